captura_entradas: RTL
=====================

Name: captura_entradas

Overview:
- Input-side counterpart of the entry display path.
- Turns the 9 one-hot switches and two push-buttons into registered row/column/value selections, a game-state code, and a one-cycle write strobe toward the board memory.
- Drives the same regLinha/regColuna/regValor/estadoJogo signals that the 7-segment display logic consumes.
- Sits between the board I/O pins and the board/validation logic.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
- ERRO_CYCLES, 50000000: cycles spent in ERRO before returning to LINHA (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- switch  in  9  raw slide switches; switch[k] selects digit k+1
- key_confirma  in  1  raw confirm button, active-low
- key_cancela  in  1  raw cancel button, active-low
- celula_fixa  in  1  from board memory: cell at (regLinha,regColuna) is a given clue; valid one cycle after regLinha/regColuna change
- regLinha  out  4  selected row 1..9, 0 = none
- regColuna  out  4  selected column 1..9, 0 = none
- regValor  out  4  selected value 1..9, 0 = none
- estadoJogo  out  3  current state code (below)
- escreve  out  1  one-cycle pulse; board writes regValor at (regLinha,regColuna)
- erro  out  1  high while in ERRO

Behaviour:
- Reset (async): state LINHA, all reg* = 0, escreve = 0, erro = 0, debounce counters and synchronizers cleared to the "released" level.
- Buttons:
  - Each button passes a 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES identical samples.
  - A press event is a single-cycle pulse on the debounced falling edge (key goes low).
  - Holding a button produces exactly one event.
- Switch code:
  - Combinational from the raw switches, registered once.
  - Exactly one bit set → code = index+1 (1..9).
  - Zero or more than one bit set → code 0 (invalid).
- State codes: LINHA = 000, COLUNA = 001, VERIFICA = 010, VALOR = 011, ESCREVE = 100, ERRO = 101.
- Transitions on a confirm event:
  - LINHA with code≠0 → load regLinha = code, go to COLUNA.
  - COLUNA with code≠0 → load regColuna = code, go to VERIFICA.
  - VALOR with code≠0 → load regValor = code, go to ESCREVE.
  - A confirm with code = 0 is ignored: no state or register change.
- VERIFICA:
  - Waits exactly 1 cycle so celula_fixa reflects the new address, then samples it on the 2nd cycle.
  - celula_fixa = 1 → ERRO; 0 → VALOR.
  - Confirm and cancel events are ignored while in VERIFICA.
- ESCREVE:
  - escreve = 1 for exactly one cycle, then → LINHA.
  - regLinha, regColuna and regValor hold their values through ESCREVE and are cleared to 0 on entry to LINHA.
- ERRO:
  - erro = 1; a timer counts ERRO_CYCLES, then → LINHA with reg* cleared.
  - A confirm event in ERRO exits early to LINHA.
- Cancel event:
  - In COLUNA → LINHA, regLinha cleared.
  - In VALOR → COLUNA, regColuna cleared.
  - In LINHA, ESCREVE or VERIFICA: ignored.
- Simultaneous events: if confirm and cancel occur in the same cycle, cancel wins.
- Reset mid-operation (including mid-debounce or mid-ERRO) returns to the reset state immediately; no escreve pulse is produced.
- Unused state codes 110/111 → LINHA on the next clock.

Decomposition:
- Shared package:
  - state code constants (LINHA..ERRO), which the display-side per-state hex selection also uses;
  - the digit width (4).
- One natural sub-module, debounce_botao:
  - one instance per key;
  - parameter DEBOUNCE_CYCLES;
  - ports clk, reset, key_n, pressed_pulse.
- The switch encoder stays inline.

Test Plan:
- DEBOUNCE_CYCLES=4: key_confirma bounces 1-0-1-0 for 3 cycles, then holds low 20 cycles → exactly one confirm event; holding longer produces no second event.
- switch=9'b000000100, confirm; switch=9'b000010000, confirm; celula_fixa=0; switch=9'b100000000, confirm → regLinha=3, regColuna=5, regValor=9, one escreve pulse; next cycle estadoJogo=000 and reg*=0.
- In LINHA, switch=9'b000000011 or 9'b0, confirm → state stays 000 and regLinha stays 0.
- Row 2, column 2 with celula_fixa=1 → estadoJogo=101, erro=1 for ERRO_CYCLES=8 cycles, then 000 with reg*=0; a second run with a confirm during ERRO exits early.
- In VALOR, press cancel → estadoJogo=001, regColuna=0, regLinha kept; then press cancel and confirm in the same cycle in COLUNA → LINHA.
- Assert reset during VERIFICA and during ERRO → all outputs 0 and estadoJogo=000 immediately, with no escreve pulse.

Source files
------------

// File: rtl/captura_entradas_pkg.sv
// Shared definitions for the entry capture path: digit width, state codes and switch encoder.
// The display side uses the same state codes for its per-state hex selection.
package captura_entradas_pkg;

  localparam int unsigned DigitW = 4;
  localparam int unsigned NumSw  = 9;

  typedef enum logic [2:0] {
    StLinha    = 3'b000,
    StColuna   = 3'b001,
    StVerifica = 3'b010,
    StValor    = 3'b011,
    StEscreve  = 3'b100,
    StErro     = 3'b101
  } estado_e;

  // One bit set -> index+1; zero or several bits -> 0 (invalid selection).
  function automatic logic [DigitW-1:0] codifica_switch(input logic [NumSw-1:0] sw);
    logic [DigitW-1:0] code;
    int unsigned       ones;
    code = '0;
    ones = 0;
    for (int unsigned k = 0; k < NumSw; k++) begin
      if (sw[k]) begin
        ones++;
        code = DigitW'(k + 1);
      end
    end
    return (ones == 1) ? code : '0;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Synchronizes and debounces one active-low push-button; emits a one-cycle pulse
// when the debounced level falls (button pressed).
module debounce_botao #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed_pulse
);

  localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            nivel_q, nivel_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronized input disagrees with the accepted level;
  // any agreeing sample restarts it.
  always_comb begin
    nivel_d = nivel_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != nivel_q) begin
      if (cnt_q == CntLast) begin
        nivel_d = sync2_q;
        pulse_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      nivel_q <= 1'b1;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      nivel_q <= nivel_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_pulse = pulse_q;

endmodule

// File: rtl/captura_entradas.sv
// Converts switches and confirm/cancel buttons into registered row/column/value selections,
// a game-state code and a one-cycle write strobe toward the board memory.
module captura_entradas
  import captura_entradas_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ERRO_CYCLES     = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NumSw-1:0]  switch,
  input  logic              key_confirma,
  input  logic              key_cancela,
  input  logic              celula_fixa,
  output logic [DigitW-1:0] regLinha,
  output logic [DigitW-1:0] regColuna,
  output logic [DigitW-1:0] regValor,
  output logic [2:0]        estadoJogo,
  output logic              escreve,
  output logic              erro
);

  localparam int unsigned     ErroW    = (ERRO_CYCLES > 1) ? $clog2(ERRO_CYCLES) : 1;
  localparam logic [ErroW-1:0] ErroLast = ErroW'(ERRO_CYCLES - 1);

  logic              confirma_ev, cancela_ev, confirma;
  logic [DigitW-1:0] code_q;
  estado_e           state_q, state_d;
  logic [DigitW-1:0] linha_q, linha_d;
  logic [DigitW-1:0] coluna_q, coluna_d;
  logic [DigitW-1:0] valor_q, valor_d;
  logic              espera_q, espera_d;
  logic [ErroW-1:0]  erro_cnt_q, erro_cnt_d;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_confirma (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_confirma),
    .pressed_pulse(confirma_ev)
  );

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_cancela (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_cancela),
    .pressed_pulse(cancela_ev)
  );

  // Cancel takes priority when both events land in the same cycle.
  assign confirma = confirma_ev & ~cancela_ev;

  always_comb begin
    state_d    = state_q;
    linha_d    = linha_q;
    coluna_d   = coluna_q;
    valor_d    = valor_q;
    espera_d   = 1'b0;
    erro_cnt_d = '0;
    case (state_q)
      StLinha: begin
        if (confirma && code_q != '0) begin
          linha_d = code_q;
          state_d = StColuna;
        end
      end
      StColuna: begin
        if (cancela_ev) begin
          state_d = StLinha;
        end else if (confirma && code_q != '0) begin
          coluna_d = code_q;
          state_d  = StVerifica;
        end
      end
      StVerifica: begin
        // First cycle lets the board memory respond to the new address.
        if (!espera_q) begin
          espera_d = 1'b1;
        end else begin
          state_d = celula_fixa ? StErro : StValor;
        end
      end
      StValor: begin
        if (cancela_ev) begin
          coluna_d = '0;
          state_d  = StColuna;
        end else if (confirma && code_q != '0) begin
          valor_d = code_q;
          state_d = StEscreve;
        end
      end
      StEscreve: state_d = StLinha;
      StErro: begin
        if (confirma || erro_cnt_q == ErroLast) begin
          state_d = StLinha;
        end else begin
          erro_cnt_d = erro_cnt_q + 1'b1;
        end
      end
      default: state_d = StLinha;
    endcase
    if (state_d == StLinha) begin
      linha_d  = '0;
      coluna_d = '0;
      valor_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLinha;
      code_q     <= '0;
      linha_q    <= '0;
      coluna_q   <= '0;
      valor_q    <= '0;
      espera_q   <= 1'b0;
      erro_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= codifica_switch(switch);
      linha_q    <= linha_d;
      coluna_q   <= coluna_d;
      valor_q    <= valor_d;
      espera_q   <= espera_d;
      erro_cnt_q <= erro_cnt_d;
    end
  end

  assign regLinha   = linha_q;
  assign regColuna  = coluna_q;
  assign regValor   = valor_q;
  assign estadoJogo = state_q;
  assign escreve    = (state_q == StEscreve);
  assign erro       = (state_q == StErro);

endmodule
